// File: rtl/fp16_fma_arbiter.sv
// fp16_fma_arbiter: round-robin arbiter/sequencer sharing one FP16
// multiply-then-add pipeline (a*b + c) between NREQ requesters.
//
// This file also holds the two fixed-latency FP16 wrappers
// (fp16_mult_wrapper, fp16_add_wrapper) that the arbiter drives. They
// round to nearest-even, flush subnormals to zero, saturate to Inf and
// have no reset.
//
// Ports (fp16_fma_arbiter):
//   clk, rst                   clock; asynchronous active-high reset
//   req_valid / req_ready      per-requester request / one-hot grant
//   req_{a,b,c}_flat           operands, requester i at [(i+1)*DW-1 -: DW]
//   req_tag_flat               opaque tags, requester i at [(i+1)*TW-1 -: TW]
//   halt                       suppresses all grants while high
//   rsp_valid                  one-hot result strobe to the owning requester
//   rsp_data, rsp_tag          a*b + c and the tag of the returned operation
//   busy, inflight             operations in flight (flag / count)
//   align_err                  sticky wrapper-valid vs sideband mismatch

module fp16_mult_wrapper #(
  parameter int unsigned LAT = 6
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result
);
  logic              s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              g, st, inc;
  logic [21:0]       p, n;
  logic signed [7:0] e;
  logic [14:0]       rnd;
  logic [15:0]       res;
  logic [LAT-1:0]    v_q;
  logic [15:0]       r_q [LAT];

  always_comb begin
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != '0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != '0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == '0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == '0);
    a_zero = (a[14:10] == '0);
    b_zero = (b[14:10] == '0);
    p      = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    // Normalise so the hidden bit sits at n[21].
    n      = p[21] ? p : {p[20:0], 1'b0};
    e      = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15
             + (p[21] ? 8'sd1 : 8'sd0);
    g      = n[10];
    st     = |n[9:0];
    inc    = g & (st | n[11]);
    // A mantissa carry out of rounding ripples into the exponent field.
    rnd    = {e[4:0], n[20:11]} + {14'b0, inc};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = 16'h7e00;
    else if (a_inf || b_inf)                                       res = {s, 5'h1f, 10'h0};
    else if (a_zero || b_zero || !n[21] || e <= 0)                 res = {s, 15'h0};
    else if (e >= 31)                                              res = {s, 5'h1f, 10'h0};
    else                                                           res = {s, rnd};
  end

  always_ff @(posedge clk) begin
    v_q[0] <= valid_in;
    r_q[0] <= res;
    for (int unsigned i = 1; i < LAT; i++) begin
      v_q[i] <= v_q[i-1];
      r_q[i] <= r_q[i-1];
    end
  end

  assign valid_out = v_q[LAT-1];
  assign result    = r_q[LAT-1];
endmodule

module fp16_add_wrapper #(
  parameter int unsigned LAT = 11
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result
);
  logic              sw, sub, x_nan, y_nan, x_inf, y_inf, lost, g, st, inc;
  logic [15:0]       x, y, res;
  logic [4:0]        d, lz;
  logic [25:0]       xw, yf, yw, sum, n;
  logic signed [7:0] e;
  logic [14:0]       rnd;
  logic [LAT-1:0]    v_q;
  logic [15:0]       r_q [LAT];

  always_comb begin
    // x is the operand of larger magnitude, so alignment only shifts y.
    sw    = (b[14:0] > a[14:0]);
    x     = sw ? b : a;
    y     = sw ? a : b;
    sub   = x[15] ^ y[15];
    x_nan = (x[14:10] == 5'h1f) && (x[9:0] != '0);
    y_nan = (y[14:10] == 5'h1f) && (y[9:0] != '0);
    x_inf = (x[14:10] == 5'h1f) && (x[9:0] == '0);
    y_inf = (y[14:10] == 5'h1f) && (y[9:0] == '0);
    d     = x[14:10] - y[14:10];
    xw    = (x[14:10] == '0) ? '0 : {1'b0, 1'b1, x[9:0], 14'b0};
    yf    = (y[14:10] == '0) ? '0 : {1'b0, 1'b1, y[9:0], 14'b0};
    yw    = yf >> d;
    // Bits shifted past the LSB collapse into a sticky LSB; 14 guard bits
    // keep that below the rounding point after any normalisation shift.
    lost  = ((yw << d) != yf);
    yw    = yw | {25'b0, lost};
    sum   = sub ? (xw - yw) : (xw + yw);
    lz    = '0;
    for (int unsigned i = 0; i < 26; i++) begin
      if (sum[i]) lz = 5'(25 - i);
    end
    n     = sum << lz;
    e     = $signed({3'b0, x[14:10]}) + 8'sd1 - $signed({3'b0, lz});
    g     = n[14];
    st    = |n[13:0];
    inc   = g & (st | n[15]);
    rnd   = {e[4:0], n[24:15]} + {14'b0, inc};
    if (x_nan || y_nan || (x_inf && y_inf && sub)) res = 16'h7e00;
    else if (x_inf)                                res = {x[15], 5'h1f, 10'h0};
    else if (!n[25])                               res = {x[15] & ~sub, 15'h0};
    else if (e <= 0)                               res = {x[15], 15'h0};
    else if (e >= 31)                              res = {x[15], 5'h1f, 10'h0};
    else                                           res = {x[15], rnd};
  end

  always_ff @(posedge clk) begin
    v_q[0] <= valid_in;
    r_q[0] <= res;
    for (int unsigned i = 1; i < LAT; i++) begin
      v_q[i] <= v_q[i-1];
      r_q[i] <= r_q[i-1];
    end
  end

  assign valid_out = v_q[LAT-1];
  assign result    = r_q[LAT-1];
endmodule

module fp16_fma_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned TW    = 8,
  parameter int unsigned M_LAT = 6,
  parameter int unsigned A_LAT = 11
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  output logic [NREQ-1:0]                      req_ready,
  input  logic [NREQ*DW-1:0]                   req_a_flat,
  input  logic [NREQ*DW-1:0]                   req_b_flat,
  input  logic [NREQ*DW-1:0]                   req_c_flat,
  input  logic [NREQ*TW-1:0]                   req_tag_flat,
  input  logic                                 halt,
  output logic [NREQ-1:0]                      rsp_valid,
  output logic [DW-1:0]                        rsp_data,
  output logic [TW-1:0]                        rsp_tag,
  output logic                                 busy,
  output logic [$clog2(M_LAT+A_LAT+2)-1:0]     inflight,
  output logic                                 align_err
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(M_LAT + A_LAT + 2);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, gnt_id, scan_idx;
  logic [NREQ-1:0] gnt;
  logic            found, xfer;
  logic [DW-1:0]   a_sel, b_sel, c_sel;
  logic [TW-1:0]   tag_sel;

  // Issue register and sideband pipelines. Stage 0 of the multiply-side
  // sideband is loaded together with the multiplier inputs, so stage M_LAT
  // lines up with the multiplier valid_out.
  logic [DW-1:0]    mul_a_q, mul_b_q;
  logic [M_LAT:0]   sbm_v_q;
  logic [DW-1:0]    sbm_c_q   [M_LAT+1];
  logic [IDW-1:0]   sbm_id_q  [M_LAT+1];
  logic [TW-1:0]    sbm_tag_q [M_LAT+1];
  logic [A_LAT-1:0] sba_v_q;
  logic [IDW-1:0]   sba_id_q  [A_LAT];
  logic [TW-1:0]    sba_tag_q [A_LAT];

  logic            mul_vo, add_vo, rsp_done, mismatch;
  logic [DW-1:0]   mul_out, add_out;

  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [TW-1:0]   rsp_tag_q, rsp_tag_d;
  logic [CW-1:0]   inflight_q, inflight_d, mask_q, mask_d;
  logic            align_err_q, align_err_d;

  // Cyclic first-valid scan starting at rr_ptr.
  always_comb begin
    gnt      = '0;
    gnt_id   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[scan_idx]) begin
        found         = 1'b1;
        gnt[scan_idx] = 1'b1;
        gnt_id        = scan_idx;
      end
    end
    req_ready = (rst || halt) ? '0 : gnt;
    xfer      = |req_ready;
    rr_ptr_d  = rr_ptr_q;
    if (xfer) rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    a_sel     = req_a_flat[gnt_id*DW +: DW];
    b_sel     = req_b_flat[gnt_id*DW +: DW];
    c_sel     = req_c_flat[gnt_id*DW +: DW];
    tag_sel   = req_tag_flat[gnt_id*TW +: TW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      sbm_v_q  <= '0;
      sba_v_q  <= '0;
      for (int unsigned i = 0; i <= M_LAT; i++) begin
        sbm_c_q[i]   <= '0;
        sbm_id_q[i]  <= '0;
        sbm_tag_q[i] <= '0;
      end
      for (int unsigned i = 0; i < A_LAT; i++) begin
        sba_id_q[i]  <= '0;
        sba_tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      mul_a_q      <= a_sel;
      mul_b_q      <= b_sel;
      sbm_v_q      <= {sbm_v_q[M_LAT-1:0], xfer};
      sbm_c_q[0]   <= c_sel;
      sbm_id_q[0]  <= gnt_id;
      sbm_tag_q[0] <= tag_sel;
      for (int unsigned i = 1; i <= M_LAT; i++) begin
        sbm_c_q[i]   <= sbm_c_q[i-1];
        sbm_id_q[i]  <= sbm_id_q[i-1];
        sbm_tag_q[i] <= sbm_tag_q[i-1];
      end
      sba_v_q      <= {sba_v_q[A_LAT-2:0], sbm_v_q[M_LAT]};
      sba_id_q[0]  <= sbm_id_q[M_LAT];
      sba_tag_q[0] <= sbm_tag_q[M_LAT];
      for (int unsigned i = 1; i < A_LAT; i++) begin
        sba_id_q[i]  <= sba_id_q[i-1];
        sba_tag_q[i] <= sba_tag_q[i-1];
      end
    end
  end

  fp16_mult_wrapper #(.LAT(M_LAT)) u_mul (
    .clk       (clk),
    .valid_in  (sbm_v_q[0]),
    .a         (mul_a_q),
    .b         (mul_b_q),
    .valid_out (mul_vo),
    .result    (mul_out)
  );

  fp16_add_wrapper #(.LAT(A_LAT)) u_add (
    .clk       (clk),
    .valid_in  (mul_vo),
    .a         (sbm_c_q[M_LAT]),
    .b         (mul_out),
    .valid_out (add_vo),
    .result    (add_out)
  );

  // Responses are qualified by the reset-cleared sideband valid, never by
  // the unreset wrapper valid, so stale wrapper pulses cannot leak out.
  always_comb begin
    rsp_done    = sba_v_q[A_LAT-1];
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (rsp_done) begin
      rsp_valid_d[sba_id_q[A_LAT-1]] = 1'b1;
      rsp_data_d = add_out;
      rsp_tag_d  = sba_tag_q[A_LAT-1];
    end
    inflight_d = inflight_q;
    if (xfer && !rsp_done)      inflight_d = inflight_q + 1'b1;
    else if (!xfer && rsp_done) inflight_d = inflight_q - 1'b1;
    mask_d      = (mask_q != '0) ? mask_q - 1'b1 : mask_q;
    mismatch    = (mul_vo != sbm_v_q[M_LAT]) || (add_vo != sba_v_q[A_LAT-1]);
    align_err_d = align_err_q | ((mask_q == '0) & mismatch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      inflight_q  <= '0;
      mask_q      <= CW'(M_LAT + A_LAT + 1);
      align_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      inflight_q  <= inflight_d;
      mask_q      <= mask_d;
      align_err_q <= align_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign inflight  = inflight_q;
  assign busy      = (inflight_q != '0);
  assign align_err = align_err_q;
endmodule

// File: doc/fp16_fma_arbiter.md
# fp16_fma_arbiter

Round-robin arbiter and sequencer that shares one FP16 multiply-then-add pipeline (fp16_mult_wrapper feeding fp16_add_wrapper) between NREQ requesters, computing a*b + c per issued operation. It sits between the SSM compute blocks (output, state-update and similar accumulation loops) and the single multiplier/adder pair, so those blocks do not each instantiate their own. Sideband (requester id, tag, addend c) is carried in fixed-latency shift registers aligned to the wrapper latencies. Each result is returned to its requester with its tag.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 16, data width (FP16)
- TW, 8, opaque requester tag width
- M_LAT, 6, fp16_mult_wrapper latency, valid_in to valid_out
- A_LAT, 11, fp16_add_wrapper latency, valid_in to valid_out

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_a_flat  in  NREQ*DW  multiplicand a, requester i at [(i+1)*DW-1 -: DW]
- req_b_flat  in  NREQ*DW  multiplier b, same packing
- req_c_flat  in  NREQ*DW  addend c, same packing
- req_tag_flat  in  NREQ*TW  tag, same packing with TW
- halt  in  1  when high, no grants are issued
- rsp_valid  out  NREQ  one-hot result strobe to the owning requester
- rsp_data  out  DW  a*b + c result
- rsp_tag  out  TW  tag of the returned operation
- busy  out  1  at least one operation in flight
- inflight  out  $clog2(M_LAT+A_LAT+2)  count of operations in flight
- align_err  out  1  sticky: wrapper valid disagreed with internal tracking

## Operation
- Grant is combinational: req_ready = 0 if halt, otherwise a one-hot select of the first req_valid at or after rr_ptr (cyclic scan). At most one grant per cycle.
- rr_ptr resets to 0. After a transfer from requester i, rr_ptr <= (i+1) mod NREQ. It is unchanged when there is no transfer.
- Issue stage, on the transfer edge: the multiplier inputs are set to a, b with valid_in = 1. c, id and tag enter stage 0 of an M_LAT-deep sideband shift register with a valid bit. With no transfer, valid_in = 0 and the stage-0 valid bit = 0.
- The M_LAT-stage sideband output drives the adder's a input (c). The adder b input is the multiplier out. Adder valid_in is the multiplier valid_out.
- id and tag then pass through an A_LAT-stage shift register. Its output valid bit selects rsp_valid[id]. rsp_data is the adder out; rsp_tag is the delayed tag.
- rsp_data and rsp_tag are don't-care when rsp_valid = 0.
- inflight: +1 on transfer, -1 on rsp, unchanged when both happen in the same cycle. busy = (inflight != 0).
- align_err sets when multiplier valid_out != the M_LAT-stage valid bit, or adder valid_out != the A_LAT-stage valid bit. It is cleared only by rst.
- Post-reset mask: the wrappers have no reset, so the align_err comparison is masked for M_LAT+A_LAT+1 cycles after rst deasserts, using a mask counter.
- Arithmetic rounding, NaN and Inf handling are those of the wrappers; the block adds no arithmetic.

## Timing
- Reset values: req_ready 0 (held 0 while rst), rsp_valid 0, rsp_data 0, rsp_tag 0, busy 0, inflight 0, align_err 0. rr_ptr and all sideband valids are 0.
- Latency: a transfer sampled at edge E produces rsp_valid high for exactly one cycle following edge E + 1 + M_LAT + A_LAT. This is 18 cycles at the defaults.
- Throughput: one issue per cycle sustained; the pipeline never stalls. Requesters must accept rsp without backpressure.
- halt takes effect in the same cycle it is asserted. Operations already in flight complete and respond normally.
- Changing req_* while req_valid is high and not granted is legal; the values are sampled only on the transfer edge.
- Reset mid-operation: all in-flight operations are discarded with no rsp_valid, and inflight returns to 0. Late wrapper valid_out pulses after reset are ignored via the mask counter.
- Two results can never collide, because issue is serialized one per cycle through a fixed-latency path.

## Test plan
- Single op: requester 2 issues a=0x4000 (2.0), b=0x4200 (3.0), c=0x3C00 (1.0), tag 0x5A -> 18 cycles later rsp_valid=4'b0100, rsp_data=0x4700 (7.0), rsp_tag=0x5A; inflight goes 1 then 0.
- Fairness: all four req_valid held high for 8 cycles from reset -> grants issued in order 0,1,2,3,0,1,2,3; responses return in the same order with matching tags.
- Pointer: only requesters 1 and 3 valid after a grant to 3 -> next grant is 1, then 3; idle cycles leave rr_ptr unchanged.
- halt: assert halt for 5 cycles with requests pending -> req_ready=0 throughout; responses already in flight still arrive; issuing resumes in the cycle halt drops.
- Streaming: 40 back-to-back ops with random operands -> every rsp matches the reference model in order; inflight peaks at 18; align_err stays 0.
- Reset mid-flight: assert rst 5 cycles after 3 issues -> no rsp_valid afterwards, inflight=0, align_err=0; a subsequent op completes with correct latency.
